// File: rtl/msrv32_alu_arbiter.sv
// rtl/msrv32_alu_arbiter.sv - two-requester round-robin front end for a shared ALU with a one-deep response register
// Optional illegal-opcode flagging is enabled by defining MSRV32_ALU_OPCODE_CHECK_EN.
module msrv32_alu_arbiter #(
  parameter int TAG_W = 4
) (
  input  logic             ms_riscv32_mp_clk_in,
  input  logic             ms_riscv32_mp_rst_in,
  input  logic             req0_valid_in,
  output logic             req0_ready_out,
  input  logic [31:0]      req0_op_1_in,
  input  logic [31:0]      req0_op_2_in,
  input  logic [3:0]       req0_opcode_in,
  input  logic [TAG_W-1:0] req0_tag_in,
  input  logic             req1_valid_in,
  output logic             req1_ready_out,
  input  logic [31:0]      req1_op_1_in,
  input  logic [31:0]      req1_op_2_in,
  input  logic [3:0]       req1_opcode_in,
  input  logic [TAG_W-1:0] req1_tag_in,
  output logic [31:0]      alu_op_1_out,
  output logic [31:0]      alu_op_2_out,
  output logic [3:0]       alu_opcode_out,
  input  logic [31:0]      alu_result_in,
  output logic             rsp_valid_out,
  input  logic             rsp_ready_in,
  output logic             rsp_id_out,
  output logic [TAG_W-1:0] rsp_tag_out,
  output logic [31:0]      rsp_result_out,
  output logic             rsp_err_out,
  output logic [15:0]      stall_cnt_out
);

  logic             slot_free;
  logic             gnt_valid;
  logic             gnt_id;
  logic             accept;
  logic             last_grant;
  logic             err_next;
  logic [TAG_W-1:0] gnt_tag;
  logic [31:0]      result_next;

  assign slot_free = !rsp_valid_out || rsp_ready_in;

  // On contention the requester that did not win last time gets the grant.
  always_comb begin
    gnt_valid = req0_valid_in || req1_valid_in;
    gnt_id    = 1'b0;
    if (req0_valid_in && req1_valid_in) begin
      gnt_id = ~last_grant;
    end else if (req1_valid_in) begin
      gnt_id = 1'b1;
    end
  end

  assign accept         = gnt_valid && slot_free && ms_riscv32_mp_rst_in;
  assign req0_ready_out = accept && !gnt_id;
  assign req1_ready_out = accept && gnt_id;

  always_comb begin
    alu_op_1_out   = '0;
    alu_op_2_out   = '0;
    alu_opcode_out = '0;
    gnt_tag        = '0;
    if (gnt_valid) begin
      if (gnt_id) begin
        alu_op_1_out   = req1_op_1_in;
        alu_op_2_out   = req1_op_2_in;
        alu_opcode_out = req1_opcode_in;
        gnt_tag        = req1_tag_in;
      end else begin
        alu_op_1_out   = req0_op_1_in;
        alu_op_2_out   = req0_op_2_in;
        alu_opcode_out = req0_opcode_in;
        gnt_tag        = req0_tag_in;
      end
    end
  end

`ifdef MSRV32_ALU_OPCODE_CHECK_EN
  always_comb begin
    err_next = 1'b1;
    case (alu_opcode_out)
      4'b0000, 4'b1000, 4'b0010, 4'b0011, 4'b0111,
      4'b0110, 4'b0100, 4'b0001, 4'b0101, 4'b1101: err_next = 1'b0;
      default: err_next = 1'b1;
    endcase
  end
  assign result_next = err_next ? 32'd0 : alu_result_in;
`else
  assign err_next    = 1'b0;
  assign result_next = alu_result_in;
`endif

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      rsp_valid_out  <= 1'b0;
      rsp_id_out     <= 1'b0;
      rsp_tag_out    <= '0;
      rsp_result_out <= '0;
      rsp_err_out    <= 1'b0;
      stall_cnt_out  <= '0;
      last_grant     <= 1'b1;
    end else begin
      if (accept) begin
        rsp_valid_out  <= 1'b1;
        rsp_id_out     <= gnt_id;
        rsp_tag_out    <= gnt_tag;
        rsp_result_out <= result_next;
        rsp_err_out    <= err_next;
        last_grant     <= gnt_id;
      end else if (rsp_ready_in) begin
        rsp_valid_out <= 1'b0;
      end
      if (gnt_valid && !accept && (stall_cnt_out != 16'hFFFF)) begin
        stall_cnt_out <= stall_cnt_out + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_msrv32_alu_arbiter.sv
// tb/tb_msrv32_alu_arbiter.sv - directed self-checking bench for msrv32_alu_arbiter
// Opcode-check expectations follow MSRV32_ALU_OPCODE_CHECK_EN.
module tb_msrv32_alu_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_op_1, req0_op_2, req1_op_1, req1_op_2;
  logic [3:0]  req0_opcode, req1_opcode;
  logic [3:0]  req0_tag, req1_tag;
  logic [31:0] alu_op_1, alu_op_2, alu_result;
  logic [3:0]  alu_opcode;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [3:0]  rsp_tag;
  logic [31:0] rsp_result;
  logic [15:0] stall_cnt;
  int          tests;
  int          fails;

  msrv32_alu_arbiter #(.TAG_W(4)) dut (
    .ms_riscv32_mp_clk_in(clk),
    .ms_riscv32_mp_rst_in(rst),
    .req0_valid_in(req0_valid),
    .req0_ready_out(req0_ready),
    .req0_op_1_in(req0_op_1),
    .req0_op_2_in(req0_op_2),
    .req0_opcode_in(req0_opcode),
    .req0_tag_in(req0_tag),
    .req1_valid_in(req1_valid),
    .req1_ready_out(req1_ready),
    .req1_op_1_in(req1_op_1),
    .req1_op_2_in(req1_op_2),
    .req1_opcode_in(req1_opcode),
    .req1_tag_in(req1_tag),
    .alu_op_1_out(alu_op_1),
    .alu_op_2_out(alu_op_2),
    .alu_opcode_out(alu_opcode),
    .alu_result_in(alu_result),
    .rsp_valid_out(rsp_valid),
    .rsp_ready_in(rsp_ready),
    .rsp_id_out(rsp_id),
    .rsp_tag_out(rsp_tag),
    .rsp_result_out(rsp_result),
    .rsp_err_out(rsp_err),
    .stall_cnt_out(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stand-in for the shared ALU; unknown opcodes return a marker value.
  always_comb begin
    case (alu_opcode)
      4'b0000: alu_result = alu_op_1 + alu_op_2;
      4'b1000: alu_result = alu_op_1 - alu_op_2;
      4'b0010: alu_result = ($signed(alu_op_1) < $signed(alu_op_2)) ? 32'd1 : 32'd0;
      4'b0011: alu_result = (alu_op_1 < alu_op_2) ? 32'd1 : 32'd0;
      4'b0111: alu_result = alu_op_1 & alu_op_2;
      4'b0110: alu_result = alu_op_1 | alu_op_2;
      4'b0100: alu_result = alu_op_1 ^ alu_op_2;
      4'b0001: alu_result = alu_op_1 << alu_op_2[4:0];
      4'b0101: alu_result = alu_op_1 >> alu_op_2[4:0];
      4'b1101: alu_result = $signed(alu_op_1) >>> alu_op_2[4:0];
      default: alu_result = 32'hDEAD_BEEF;
    endcase
  end

  task automatic clear_reqs();
    req0_valid = 0; req0_op_1 = 0; req0_op_2 = 0; req0_opcode = 0; req0_tag = 0;
    req1_valid = 0; req1_op_1 = 0; req1_op_2 = 0; req1_opcode = 0; req1_tag = 0;
  endtask

  task automatic do_reset();
    clear_reqs();
    rst = 0;
    @(posedge clk); #1;
    rst = 1;
  endtask

  task automatic test_reset();
    clear_reqs();
    rsp_ready = 1;
    rst = 0;
    req0_valid = 1; req1_valid = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b%b exp 00", req0_ready, req1_ready); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b exp 0", rsp_valid); end
    tests++; if (stall_cnt !== 16'd0) begin fails++; $display("FAIL reset_stall: got %0d exp 0", stall_cnt); end
    tests++; if (rsp_result !== 32'd0 || rsp_tag !== 4'd0 || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin fails++; $display("FAIL reset_rsp_fields: result %h tag %h id %b err %b exp all 0", rsp_result, rsp_tag, rsp_id, rsp_err); end
    clear_reqs();
    rst = 1;
  endtask

  task automatic test_single();
    do_reset();
    rsp_ready = 1;
    req0_valid = 1; req0_op_1 = 5; req0_op_2 = 3; req0_opcode = 4'b0000; req0_tag = 2;
    #1;
    tests++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin fails++; $display("FAIL single_ready: got %b%b exp 10", req0_ready, req1_ready); end
    tests++; if (alu_op_1 !== 32'd5 || alu_op_2 !== 32'd3 || alu_opcode !== 4'd0) begin fails++; $display("FAIL single_alu_drive: got %0d %0d %h exp 5 3 0", alu_op_1, alu_op_2, alu_opcode); end
    @(posedge clk); #1;
    tests++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_tag !== 4'd2 || rsp_result !== 32'd8) begin fails++; $display("FAIL single_rsp: valid %b id %b tag %0d result %0d exp 1 0 2 8", rsp_valid, rsp_id, rsp_tag, rsp_result); end
    req0_valid = 0;
    #1;
    tests++; if (alu_op_1 !== 32'd0 || alu_op_2 !== 32'd0 || alu_opcode !== 4'd0) begin fails++; $display("FAIL idle_alu_zero: got %h %h %h exp 0 0 0", alu_op_1, alu_op_2, alu_opcode); end
    @(posedge clk); #1;
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL single_drain: got %b exp 0", rsp_valid); end
    tests++; if (stall_cnt !== 16'd0) begin fails++; $display("FAIL single_stall: got %0d exp 0", stall_cnt); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    rsp_ready = 1;
    req0_valid = 1; req0_op_1 = 10; req0_op_2 = 20; req0_opcode = 4'b0000; req0_tag = 1;
    req1_valid = 1; req1_op_1 = 7;  req1_op_2 = 3;  req1_opcode = 4'b1000; req1_tag = 3;
    for (int i = 0; i < 6; i++) begin
      #1;
      tests++; if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin fails++; $display("FAIL alt_ready[%0d]: got %b%b exp %b%b", i, req0_ready, req1_ready, (i % 2 == 0), (i % 2 == 1)); end
      @(posedge clk); #1;
      tests++;
      if (rsp_valid !== 1'b1 || rsp_id !== (i % 2 == 1) || rsp_result !== ((i % 2 == 0) ? 32'd30 : 32'd4) || rsp_tag !== ((i % 2 == 0) ? 4'd1 : 4'd3)) begin
        fails++; $display("FAIL alt_rsp[%0d]: valid %b id %b result %0d tag %0d", i, rsp_valid, rsp_id, rsp_result, rsp_tag);
      end
    end
    tests++; if (stall_cnt !== 16'd0) begin fails++; $display("FAIL alt_stall: got %0d exp 0", stall_cnt); end
    clear_reqs();
  endtask

  task automatic test_stall();
    do_reset();
    rsp_ready = 0;
    req1_valid = 1; req1_op_1 = 32'hFFFF_FFFF; req1_op_2 = 1; req1_opcode = 4'b0010; req1_tag = 5;
    #1;
    tests++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin fails++; $display("FAIL stall_first_ready: got %b%b exp 01", req0_ready, req1_ready); end
    @(posedge clk); #1;
    tests++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd1 || rsp_id !== 1'b1) begin fails++; $display("FAIL stall_first_rsp: valid %b result %0d id %b exp 1 1 1", rsp_valid, rsp_result, rsp_id); end
    req0_valid = 1; req0_op_1 = 1; req0_op_2 = 2; req0_opcode = 4'b0000; req0_tag = 9;
    req1_op_1 = 0; req1_tag = 7;
    for (int k = 1; k <= 3; k++) begin
      #1;
      tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin fails++; $display("FAIL stall_ready[%0d]: got %b%b exp 00", k, req0_ready, req1_ready); end
      @(posedge clk); #1;
      tests++;
      if (rsp_valid !== 1'b1 || rsp_result !== 32'd1 || rsp_tag !== 4'd5 || rsp_id !== 1'b1 || stall_cnt !== 16'(k)) begin
        fails++; $display("FAIL stall_hold[%0d]: valid %b result %0d tag %0d id %b stall %0d exp 1 1 5 1 %0d", k, rsp_valid, rsp_result, rsp_tag, rsp_id, stall_cnt, k);
      end
    end
    rsp_ready = 1;
    #1;
    tests++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin fails++; $display("FAIL stall_release_ready: got %b%b exp 10", req0_ready, req1_ready); end
    @(posedge clk); #1;
    tests++; if (rsp_id !== 1'b0 || rsp_result !== 32'd3 || rsp_tag !== 4'd9 || stall_cnt !== 16'd3) begin fails++; $display("FAIL stall_release_rsp: id %b result %0d tag %0d stall %0d exp 0 3 9 3", rsp_id, rsp_result, rsp_tag, stall_cnt); end
    clear_reqs();
  endtask

  task automatic test_opcode_check();
    do_reset();
    rsp_ready = 1;
    req0_valid = 1; req0_op_1 = 5; req0_op_2 = 3; req0_opcode = 4'b1111; req0_tag = 4;
    @(posedge clk); #1;
`ifdef MSRV32_ALU_OPCODE_CHECK_EN
    tests++; if (rsp_err !== 1'b1 || rsp_result !== 32'd0) begin fails++; $display("FAIL opcode_illegal: err %b result %h exp 1 0", rsp_err, rsp_result); end
`else
    tests++; if (rsp_err !== 1'b0 || rsp_result !== 32'hDEAD_BEEF) begin fails++; $display("FAIL opcode_illegal: err %b result %h exp 0 deadbeef", rsp_err, rsp_result); end
`endif
    req0_op_1 = 32'h8000_0000; req0_op_2 = 4; req0_opcode = 4'b1101;
    @(posedge clk); #1;
    tests++; if (rsp_err !== 1'b0 || rsp_result !== 32'hF800_0000) begin fails++; $display("FAIL opcode_sra: err %b result %h exp 0 f8000000", rsp_err, rsp_result); end
    clear_reqs();
  endtask

  task automatic test_reset_pending();
    do_reset();
    rsp_ready = 0;
    req0_valid = 1; req0_op_1 = 1; req0_op_2 = 1; req0_opcode = 4'b0000; req0_tag = 6;
    @(posedge clk); #1;
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL pending_valid: got %b exp 1", rsp_valid); end
    req1_valid = 1;
    @(posedge clk); #1;
    rst = 0;
    #1;
    tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin fails++; $display("FAIL pending_reset_ready: got %b%b exp 00", req0_ready, req1_ready); end
    @(posedge clk); #1;
    tests++; if (rsp_valid !== 1'b0 || stall_cnt !== 16'd0) begin fails++; $display("FAIL pending_discard: valid %b stall %0d exp 0 0", rsp_valid, stall_cnt); end
    rst = 1;
    rsp_ready = 1;
    #1;
    tests++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin fails++; $display("FAIL pending_first_grant: got %b%b exp 10", req0_ready, req1_ready); end
    @(posedge clk); #1;
    tests++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_tag !== 4'd6) begin fails++; $display("FAIL pending_after_rsp: valid %b id %b tag %0d exp 1 0 6", rsp_valid, rsp_id, rsp_tag); end
    clear_reqs();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 0;
    rsp_ready = 0;
    clear_reqs();
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_opcode_check();
    test_reset_pending();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
